// File: rtl/pe_feeder_pkg.sv
// Shared types, widths and limits for the PE feeder: FSM state encoding and
// the legality check applied to each pass command.
package pe_feeder_pkg;

  localparam int P_W        = 5;
  localparam int Q_W        = 3;
  localparam int S_W        = 4;
  localparam int PASS_CNT_W = 10;

  localparam int PSUM_DEPTH  = 24;
  localparam int IFMAP_DEPTH = 12;
  localparam int FILT_DEPTH  = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    GAP1,
    LOAD_I,
    GAP2,
    COMPUTE,
    DRAIN_WAIT,
    DRAIN
  } state_t;

  // A pass is legal only if every spad it touches is large enough; the limits
  // are passed in so a parameterised feeder checks against its own sizes.
  function automatic logic cfg_legal(input logic [P_W-1:0] p,
                                     input logic [Q_W-1:0] q,
                                     input logic [S_W-1:0] s,
                                     input int psum_depth,
                                     input int ifmap_depth,
                                     input int filt_depth);
    int qs;
    int pqs;
    qs  = int'(q) * int'(s);
    pqs = int'(p) * qs;
    return (p != '0) && (int'(p) <= psum_depth) &&
           (q != '0) && (s != '0) &&
           (pqs <= filt_depth) && (qs <= ifmap_depth);
  endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// Bundle of the feeder's command, GLB stream, PE control and psum stream signals.
// Modport master is the feeder itself; slave is the scheduler/GLB/PE side.
interface pe_feeder_if #(
  parameter int DATA_W = 16,
  parameter int PSUM_W = 32
);
  import pe_feeder_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [P_W-1:0]    cfg_P;
  logic [Q_W-1:0]    cfg_Q;
  logic [S_W-1:0]    cfg_S;

  logic              filt_valid;
  logic              filt_ready;
  logic [DATA_W-1:0] filt_data;

  logic              ifmap_valid;
  logic              ifmap_ready;
  logic [DATA_W-1:0] ifmap_data;

  logic              load_f;
  logic              load_i;
  logic              start;
  logic [DATA_W-1:0] pe_wdata;
  logic [PSUM_W-1:0] pe_psum_data;

  logic              psum_valid;
  logic              psum_ready;
  logic [PSUM_W-1:0] psum_data;

  logic              busy;
  logic              err_cfg;
  logic              err_underrun;

  modport master (
    input  cmd_valid, cfg_P, cfg_Q, cfg_S,
    input  filt_valid, filt_data, ifmap_valid, ifmap_data,
    input  pe_psum_data, psum_ready,
    output cmd_ready, filt_ready, ifmap_ready,
    output load_f, load_i, start, pe_wdata,
    output psum_valid, psum_data, busy, err_cfg, err_underrun
  );

  modport slave (
    output cmd_valid, cfg_P, cfg_Q, cfg_S,
    output filt_valid, filt_data, ifmap_valid, ifmap_data,
    output pe_psum_data, psum_ready,
    input  cmd_ready, filt_ready, ifmap_ready,
    input  load_f, load_i, start, pe_wdata,
    input  psum_valid, psum_data, busy, err_cfg, err_underrun
  );

endinterface

// File: rtl/pe_feeder_psum_out_fifo.sv
// First-word-fall-through skid FIFO for drained psums; the head is always
// visible on pop_data, and push plus pop in one cycle are both honoured.
module psum_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  import pe_feeder_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pe_feeder.sv
// PE load/compute/drain initiator with a psum skid FIFO on the output.
// Define PE_FEEDER_PERF_EN to add the pass and stall cycle counters.
module pe_feeder #(
  parameter int DATA_W      = 16,
  parameter int PSUM_W      = 32,
  parameter int IFMAP_DEPTH = pe_feeder_pkg::IFMAP_DEPTH,
  parameter int FILT_DEPTH  = pe_feeder_pkg::FILT_DEPTH,
  parameter int PSUM_DEPTH  = pe_feeder_pkg::PSUM_DEPTH,
  parameter int DRAIN_LAT   = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PE_FEEDER_PERF_EN
  output logic [31:0] perf_pass_cycles,
  output logic [31:0] perf_stall_cycles,
`endif
  pe_feeder_if.master bus
);
  import pe_feeder_pkg::*;

  localparam int CNT_W  = PASS_CNT_W;
  localparam int PQS_W  = $clog2(FILT_DEPTH + 1);
  localparam int QS_W   = $clog2(IFMAP_DEPTH + 1);
  localparam int PROD_W = P_W + Q_W + S_W;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [P_W-1:0]     p_q;
  logic [PQS_W-1:0]   pqs_q;
  logic [QS_W-1:0]    qs_q;
  logic               load_f_q;
  logic               load_i_q;
  logic               start_q;
  logic               err_cfg_q;
  logic               err_underrun_q;

  logic [PROD_W-1:0]  pqs_in;
  logic [Q_W+S_W-1:0] qs_in;
  logic               cfg_ok;
  logic               cmd_ready_w;
  logic               cmd_accept;
  logic [DATA_W-1:0]  wdata;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PSUM_W-1:0]  fifo_head;

  assign pqs_in      = PROD_W'(bus.cfg_P) * PROD_W'(bus.cfg_Q) * PROD_W'(bus.cfg_S);
  assign qs_in       = (Q_W+S_W)'(bus.cfg_Q) * (Q_W+S_W)'(bus.cfg_S);
  assign cfg_ok      = cfg_legal(bus.cfg_P, bus.cfg_Q, bus.cfg_S,
                                 PSUM_DEPTH, IFMAP_DEPTH, FILT_DEPTH);
  // Holding off new passes until the FIFO is empty is what makes overflow impossible.
  assign cmd_ready_w = (state == IDLE) && fifo_empty;
  assign cmd_accept  = bus.cmd_valid && cmd_ready_w;

  // Each phase loads cnt with its length minus one and advances when it hits zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      p_q            <= '0;
      pqs_q          <= '0;
      qs_q           <= '0;
      load_f_q       <= 1'b0;
      load_i_q       <= 1'b0;
      start_q        <= 1'b0;
      err_cfg_q      <= 1'b0;
      err_underrun_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_accept) begin
            err_cfg_q      <= !cfg_ok;
            err_underrun_q <= 1'b0;
            if (cfg_ok) begin
              p_q      <= bus.cfg_P;
              pqs_q    <= PQS_W'(pqs_in);
              qs_q     <= QS_W'(qs_in);
              cnt      <= CNT_W'(pqs_in) - CNT_W'(1);
              load_f_q <= 1'b1;
              state    <= LOAD_F;
            end
          end
        end
        LOAD_F: begin
          if (!bus.filt_valid) err_underrun_q <= 1'b1;
          if (cnt == '0) begin
            load_f_q <= 1'b0;
            state    <= GAP1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP1: begin
          cnt      <= CNT_W'(qs_q) - CNT_W'(1);
          load_i_q <= 1'b1;
          state    <= LOAD_I;
        end
        LOAD_I: begin
          if (!bus.ifmap_valid) err_underrun_q <= 1'b1;
          if (cnt == '0) begin
            load_i_q <= 1'b0;
            state    <= GAP2;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP2: begin
          cnt     <= CNT_W'({pqs_q, 2'b00}) - CNT_W'(1);
          start_q <= 1'b1;
          state   <= COMPUTE;
        end
        COMPUTE: begin
          if (cnt == '0) begin
            start_q <= 1'b0;
            cnt     <= CNT_W'(DRAIN_LAT - 1);
            state   <= DRAIN_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DRAIN_WAIT: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(p_q) - CNT_W'(1);
            state <= DRAIN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DRAIN: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A missing word is written as zero rather than stalling, since load_f/load_i cannot gap.
  always_comb begin
    wdata = '0;
    if (load_f_q && bus.filt_valid)
      wdata = bus.filt_data;
    else if (load_i_q && bus.ifmap_valid)
      wdata = bus.ifmap_data;
  end

  assign fifo_push = (state == DRAIN) && !fifo_full;
  assign fifo_pop  = !fifo_empty && bus.psum_ready;

  psum_out_fifo #(
    .WIDTH (PSUM_W),
    .DEPTH (PSUM_DEPTH)
  ) u_psum_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.pe_psum_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.cmd_ready    = cmd_ready_w;
  assign bus.filt_ready   = load_f_q;
  assign bus.ifmap_ready  = load_i_q;
  assign bus.load_f       = load_f_q;
  assign bus.load_i       = load_i_q;
  assign bus.start        = start_q;
  assign bus.pe_wdata     = wdata;
  assign bus.psum_valid   = !fifo_empty;
  assign bus.psum_data    = fifo_head;
  assign bus.busy         = (state != IDLE) || !fifo_empty;
  assign bus.err_cfg      = err_cfg_q;
  assign bus.err_underrun = err_underrun_q;

`ifdef PE_FEEDER_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_pass_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (cmd_accept) begin
      perf_pass_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((state != IDLE) && (perf_pass_cycles != '1))
        perf_pass_cycles <= perf_pass_cycles + 32'd1;
      if (!fifo_empty && !bus.psum_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pe_feeder.md
Name: pe_feeder

Overview:
- Initiator for the PE scratchpad-load / compute / drain protocol. It drives load_f, load_i and start into one PE and streams filter and ifmap words from the GLB into the PE spads.
- It times a compute pass of 4*P*Q*S cycles, then captures the P psums the PE drains. Because PE drain cannot stall, the psums go into a skid FIFO and leave through a valid/ready stream.
- Sits between the GLB/top-level scheduler and PE_ctrl plus the PE datapath.

Parameters:
- DATA_W, 16, ifmap/filter word width.
- PSUM_W, 32, psum word width.
- IFMAP_DEPTH, 12, ifmap spad entries; Q*S must not exceed this.
- FILT_DEPTH, 255, maximum P*Q*S filter words; 4*P*Q*S must fit in 10 bits.
- PSUM_DEPTH, 24, psum spad entries; maximum P; also the output FIFO depth.
- DRAIN_LAT, 4, cycles from last start cycle to first valid pe_psum_data.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid/cmd_ready  in/out  1/1  pass command handshake.
- cfg_P  in  5  filters per pass; sampled on cmd accept.
- cfg_Q  in  3  channels per pass; sampled on cmd accept.
- cfg_S  in  4  filter width; sampled on cmd accept.
- filt_valid/filt_ready/filt_data  in/out/in  1/1/DATA_W  filter stream from GLB.
- ifmap_valid/ifmap_ready/ifmap_data  in/out/in  1/1/DATA_W  ifmap stream from GLB.
- load_f, load_i, start  out  1 each  to PE_ctrl.
- pe_wdata  out  DATA_W  spad write data to PE.
- pe_psum_data  in  PSUM_W  psum read data from PE during drain.
- psum_valid/psum_ready/psum_data  out/in/out  1/1/PSUM_W  psum result stream.
- busy  out  1  high while not IDLE or FIFO non-empty.
- err_cfg, err_underrun  out  1 each  sticky error flags; cleared on next cmd accept.

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0, FIFO empty. Outputs: cmd_ready=1; load_f/load_i/start/filt_ready/ifmap_ready/psum_valid=0; pe_wdata=0; busy=0; err flags 0.
- Config latched on cmd_valid&&cmd_ready. cmd_ready=1 only in IDLE with FIFO empty.
- Legal config: 1<=P<=PSUM_DEPTH, Q>=1, S>=1, P*Q*S<=FILT_DEPTH, Q*S<=IFMAP_DEPTH.
- Illegal config: set err_cfg, stay IDLE, no PE signal toggles.
- FSM: IDLE -> LOAD_F -> GAP1 -> LOAD_I -> GAP2 -> COMPUTE -> DRAIN_WAIT -> DRAIN -> IDLE.
- LOAD_F:
  - load_f=1 and filt_ready=1 for exactly P*Q*S consecutive cycles.
  - pe_wdata=filt_data when filt_valid, else 0 and err_underrun set.
  - load_f is never gapped, because a PE address reset fires on the load_f rising edge.
- GAP1 and GAP2: one cycle each with all PE controls 0. This guarantees a fresh load_i/start rising edge.
- LOAD_I: same rules as LOAD_F for Q*S cycles, using load_i, ifmap_ready and ifmap_data.
- COMPUTE: start=1 for exactly 4*P*Q*S cycles, tracked by a 10-bit down counter. load_f and load_i are never high together with start.
- DRAIN_WAIT: DRAIN_LAT cycles idle.
- DRAIN:
  - Push pe_psum_data into the FIFO for exactly P cycles, one per cycle, no stall.
  - The FIFO cannot overflow because P<=PSUM_DEPTH and cmd_ready waits for FIFO empty.
- Return to IDLE after the P-th push. busy stays high until the FIFO drains.
- Output stream: psum_valid = FIFO non-empty and psum_data = FIFO head; pop on psum_valid&&psum_ready. Zero-cycle path: a push and a pop in the same cycle are both honoured. Order is psum_spad index 0..P-1.
- Boundaries:
  - P=1, Q=1, S=1 gives 1 load_f cycle, 1 load_i cycle, 4 start cycles, 1 drain push.
  - FIFO full plus pop with no push gives count-1.
  - cmd_valid outside IDLE is ignored.
- Reset mid-pass: immediate IDLE; load_f/load_i/start drop asynchronously; FIFO contents are discarded.

Optional Feature:
- Macro PE_FEEDER_PERF_EN.
- Defined: adds outputs perf_pass_cycles (32 bits) and perf_stall_cycles (32 bits).
  - perf_pass_cycles counts cycles from cmd accept to the IDLE return.
  - perf_stall_cycles counts cycles with psum_valid && !psum_ready.
  - Both saturate at all-ones and clear on cmd accept.
- Undefined: ports and counters absent; core behaviour unchanged.

Decomposition:
- Package pe_feeder_pkg:
  - State enum type.
  - Width constants: P_W=5, Q_W=3, S_W=4, PASS_CNT_W=10.
  - Limits: PSUM_DEPTH, IFMAP_DEPTH, FILT_DEPTH.
  - Function for the legal-config check.
- Sub-module psum_out_fifo: synchronous FIFO with async active-low reset, depth PSUM_DEPTH, push/pop/full/empty, first-word-fall-through.

Test Plan:
- P=2, Q=1, S=3, streams always valid -> load_f high 6 cycles; 1 gap cycle; load_i high 3 cycles; 1 gap cycle; start high 24 cycles; 2 psums out in order; busy falls.
- P=1, Q=1, S=1 minimal pass -> load_f 1, load_i 1, start 4, exactly 1 psum_data equal to pe_psum_data at the drain cycle.
- cfg_P=0, and separately cfg_Q=4 with cfg_S=4 (Q*S=16>12) -> err_cfg=1, load_f/load_i/start never assert, cmd_ready stays 1.
- P=24 with psum_ready=0 throughout drain -> 24 words stored with no loss; then psum_ready=1 gives 24 pops in order; cmd_ready held 0 until empty.
- filt_valid dropped for 1 cycle mid LOAD_F -> load_f stays high, pe_wdata=0 that cycle, err_underrun=1 until next cmd accept.
- rst asserted in cycle 10 of COMPUTE -> start=0 without waiting for clk, FIFO empty, cmd_ready=1 after release; the next pass completes normally.
